// File: rtl/mac_vec_sat.sv
// Pipelined multi-lane saturating dot-product accumulator: multiply, reduce, accumulate into an OUTW-bit result.
// Last beat -> out_valid after 3 edges; a held result (out_valid && !out_ready) freezes every stage and drops input_ready.
module mac_vec_sat #(
    parameter int INW   = 16,
    parameter int OUTW  = 48,
    parameter int LANES = 4,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_acc,
    input  logic                 valid_input,
    output logic                 input_ready,
    input  logic                 last_input,
    input  logic [LANES*INW-1:0] in0,
    input  logic [LANES*INW-1:0] in1,
    output logic [OUTW-1:0]      out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic [CNTW-1:0]      out_count
);
    localparam int PRW = 2 * INW;
    localparam int PW  = PRW + $clog2(LANES);
    localparam logic [OUTW-1:0] MAXVAL  = {1'b0, {(OUTW-1){1'b1}}};
    localparam logic [OUTW-1:0] MINVAL  = {1'b1, {(OUTW-1){1'b0}}};
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic                 s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [LANES*PRW-1:0] s1_prod_q, s1_prod_d;
    logic                 s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [PW-1:0]        s2_psum_q, s2_psum_d;
    logic [OUTW-1:0]      acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [OUTW-1:0]      out_q, out_d;
    logic                 out_vld_q, out_vld_d;
    logic                 out_sat_q, out_sat_d;
    logic [CNTW-1:0]      out_cnt_q, out_cnt_d;

    logic                 adv;
    logic [LANES*PRW-1:0] prod;
    logic [PW-1:0]        psum;
    logic [OUTW-1:0]      psum_ext, acc_sum, acc_sat;
    logic                 ovf;
    logic [CNTW-1:0]      cnt_inc;

    assign adv         = !(out_vld_q && !out_ready);
    assign input_ready = adv;

    always_comb begin
        logic signed [INW-1:0] a_l;
        logic signed [INW-1:0] b_l;
        a_l  = '0;
        b_l  = '0;
        prod = '0;
        for (int k = 0; k < LANES; k++) begin
            a_l = in0[k*INW +: INW];
            b_l = in1[k*INW +: INW];
            prod[k*PRW +: PRW] = PRW'(a_l) * PRW'(b_l);
        end
    end

    // PW carries $clog2(LANES) guard bits, so the lane sum can never wrap.
    always_comb begin
        logic signed [PRW-1:0] p;
        p    = '0;
        psum = '0;
        for (int k = 0; k < LANES; k++) begin
            p    = s1_prod_q[k*PRW +: PRW];
            psum = psum + PW'(p);
        end
    end

    assign psum_ext = OUTW'($signed(s2_psum_q));
    assign acc_sum  = acc_q + psum_ext;
    assign ovf      = (acc_q[OUTW-1] == psum_ext[OUTW-1]) && (acc_sum[OUTW-1] != acc_q[OUTW-1]);
    assign acc_sat  = !ovf ? acc_sum : (acc_q[OUTW-1] ? MINVAL : MAXVAL);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_prod_d = s1_prod_q;
        s2_vld_d  = s2_vld_q;
        s2_last_d = s2_last_q;
        s2_psum_d = s2_psum_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        out_sat_d = out_sat_q;
        out_cnt_d = out_cnt_q;
        if (clear_acc) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            acc_d     = '0;
            sat_d     = 1'b0;
            cnt_d     = '0;
            out_d     = '0;
            out_vld_d = 1'b0;
            out_sat_d = 1'b0;
            out_cnt_d = '0;
        end else if (adv) begin
            s1_vld_d = valid_input;
            if (valid_input) begin
                s1_last_d = last_input;
                s1_prod_d = prod;
            end
            s2_vld_d  = s1_vld_q;
            s2_last_d = s1_last_q;
            s2_psum_d = psum;
            // adv means any held result is being taken this cycle
            out_vld_d = 1'b0;
            if (s2_vld_q) begin
                if (s2_last_q) begin
                    out_d     = acc_sat;
                    out_sat_d = sat_q | ovf;
                    out_cnt_d = cnt_inc;
                    out_vld_d = 1'b1;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                    cnt_d     = '0;
                end else begin
                    acc_d = acc_sat;
                    sat_d = sat_q | ovf;
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_prod_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_psum_q <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            out_sat_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_prod_q <= s1_prod_d;
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            s2_psum_q <= s2_psum_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            out_sat_q <= out_sat_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_vld_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_cnt_q;

endmodule

// File: tb/tb_mac_vec_sat.sv
// Bench for mac_vec_sat: vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_mac_vec_sat;
    localparam int INW   = 16;
    localparam int OUTW  = 34;
    localparam int LANES = 4;
    localparam int CNTW  = 4;
    localparam int DW    = LANES * INW;
    localparam longint MAXV = (longint'(1) <<< (OUTW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OUTW - 1));
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset, clear_acc, valid_input, input_ready, last_input;
    logic out_valid, out_ready, out_sat;
    logic [DW-1:0] in0, in1;
    logic [OUTW-1:0] out;
    logic [CNTW-1:0] out_count;

    int checks = 0;
    int errors = 0;

    mac_vec_sat #(.INW(INW), .OUTW(OUTW), .LANES(LANES), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .clear_acc(clear_acc), .valid_input(valid_input),
        .input_ready(input_ready), .last_input(last_input), .in0(in0), .in1(in1),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input int v);
        logic [INW-1:0] l;
        l = v[INW-1:0];
        return {LANES{l}};
    endfunction

    function automatic logic [DW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [INW-1:0] l0, l1, l2, l3;
        l0 = v0[INW-1:0];
        l1 = v1[INW-1:0];
        l2 = v2[INW-1:0];
        l3 = v3[INW-1:0];
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DW-1:0] rand_lanes();
        logic [DW-1:0] r;
        int mode;
        int v;
        r = '0;
        mode = int'($urandom_range(0, 2));
        for (int k = 0; k < LANES; k++) begin
            if (mode == 0) v = int'($urandom_range(0, 15)) - 8;
            else if (mode == 1) v = int'($urandom());
            else v = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            r[k*INW +: INW] = v[INW-1:0];
        end
        return r;
    endfunction

    function automatic longint beat_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        logic signed [INW-1:0] x, y;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            x = a[k*INW +: INW];
            y = b[k*INW +: INW];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    // Present one beat from posedge+1 and hold it until an edge accepts it.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        logic rdy;
        int w;
        w = 0;
        valid_input = 1'b1;
        in0 = a;
        in1 = b;
        last_input = last;
        do begin
            rdy = input_ready;
            @(posedge clk);
            #1;
            w++;
        end while (!rdy && w < 50);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: input_ready stayed %0d for %0d cycles, required 1", rdy, w);
        end
    endtask

    task automatic wait_out(output logic got);
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Scoreboard: reference model fed with every accepted beat, compared at each output handshake.
    logic   sb_en = 1'b0;
    longint m_acc;
    logic   m_sat;
    int     m_cnt;
    longint exp_v[$];
    logic   exp_s[$];
    int     exp_c[$];
    logic   prev_stall;
    logic [OUTW+CNTW:0] prev_out;

    always @(negedge clk) begin
        longint t;
        if (!sb_en) begin
            m_acc = 0;
            m_sat = 1'b0;
            m_cnt = 0;
            prev_stall = 1'b0;
        end else if (!reset) begin
            if (prev_stall)
                check("stall_hold", longint'(out_valid && ({out, out_sat, out_count} == prev_out)), 1);
            if (valid_input && input_ready && !clear_acc) begin
                t = m_acc + beat_sum(in0, in1);
                if (t > MAXV) begin
                    t = MAXV;
                    m_sat = 1'b1;
                end else if (t < MINV) begin
                    t = MINV;
                    m_sat = 1'b1;
                end
                m_acc = t;
                if (m_cnt < CMAX) m_cnt++;
                if (last_input) begin
                    exp_v.push_back(m_acc);
                    exp_s.push_back(m_sat);
                    exp_c.push_back(m_cnt);
                    m_acc = 0;
                    m_sat = 1'b0;
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_v.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result %0d, required none", $signed(out));
                end else begin
                    check("sb_out", longint'($signed(out)), exp_v[0]);
                    check("sb_sat", longint'(out_sat), longint'(exp_s[0]));
                    check("sb_cnt", longint'(out_count), longint'(exp_c[0]));
                    exp_v.delete(0);
                    exp_s.delete(0);
                    exp_c.delete(0);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out, out_sat, out_count};
        end
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            nbeats;
        longint        e_out;
        logic          e_sat;
        int            e_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic got;
        int k;
        int n;
        longint gv[2];
        int gc[2];
        logic took;

        tbl[0] = '{pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1, 70, 1'b0, 1};
        tbl[1] = '{rep(1), rep(1), 3, 12, 1'b0, 3};
        tbl[2] = '{rep(2), rep(3), 1, 24, 1'b0, 1};
        tbl[3] = '{rep(-32768), rep(-32768), 2, MAXV, 1'b1, 2};
        tbl[4] = '{rep(-32768), rep(32767), 3, MINV, 1'b1, 3};
        tbl[5] = '{rep(0), rep(0), 20, 0, 1'b0, CMAX};
        tbl[6] = '{rep(-3), rep(7), 5, -420, 1'b0, 5};
        tbl[7] = '{rep(-32768), rep(-32768), 1, 64'sd4294967296, 1'b0, 1};

        reset = 1'b1;
        clear_acc = 1'b0;
        valid_input = 1'b0;
        last_input = 1'b0;
        in0 = '0;
        in1 = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_out", longint'(out), 0);
        check("rst_vld", longint'(out_valid), 0);
        check("rst_sat", longint'(out_sat), 0);
        check("rst_cnt", longint'(out_count), 0);
        check("rst_rdy", longint'(input_ready), 1);
        @(posedge clk);
        #1;

        // First-result latency: accepted at E, visible after E+2 for exactly one cycle.
        valid_input = 1'b1;
        in0 = pack4(1, 2, 3, 4);
        in1 = pack4(5, 6, 7, 8);
        last_input = 1'b1;
        @(posedge clk);
        #1;
        valid_input = 1'b0;
        check("lat_e0", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_e1", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_e2_vld", longint'(out_valid), 1);
        check("lat_e2_out", longint'($signed(out)), 70);
        check("lat_e2_cnt", longint'(out_count), 1);
        @(posedge clk);
        #1;
        check("lat_e3_vld", longint'(out_valid), 0);

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < tbl[i].nbeats; b++)
                send(tbl[i].a, tbl[i].b, b == tbl[i].nbeats - 1);
            valid_input = 1'b0;
            wait_out(got);
            check($sformatf("tbl%0d_vld", i), longint'(got), 1);
            check($sformatf("tbl%0d_out", i), longint'($signed(out)), tbl[i].e_out);
            check($sformatf("tbl%0d_sat", i), longint'(out_sat), longint'(tbl[i].e_sat));
            check($sformatf("tbl%0d_cnt", i), longint'(out_count), longint'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Back-to-back vectors with no gap between them.
        send(rep(1), rep(1), 1'b0);
        send(rep(1), rep(1), 1'b0);
        send(rep(1), rep(1), 1'b1);
        send(rep(2), rep(3), 1'b1);
        valid_input = 1'b0;
        n = 0;
        gv[0] = 0; gv[1] = 0; gc[0] = 0; gc[1] = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && n < 2) begin
                gv[n] = longint'($signed(out));
                gc[n] = int'(out_count);
                n++;
            end
            @(posedge clk);
            #1;
        end
        check("ng_n", longint'(n), 2);
        check("ng_a_out", gv[0], 12);
        check("ng_a_cnt", longint'(gc[0]), 3);
        check("ng_b_out", gv[1], 24);
        check("ng_b_cnt", longint'(gc[1]), 1);

        // Backpressure: single-beat vectors 4k streamed while out_ready is low for five cycles.
        sb_en = 1'b1;
        out_ready = 1'b0;
        k = 1;
        valid_input = 1'b1;
        last_input = 1'b1;
        in0 = rep(1);
        in1 = rep(1);
        for (int c = 0; c < 14; c++) begin
            if (c == 7) out_ready = 1'b1;
            took = input_ready;
            @(posedge clk);
            #1;
            if (took) begin
                k++;
                in0 = rep(k);
            end
            if (c >= 2 && c <= 6) begin
                check("bp_rdy", longint'(input_ready), 0);
                check("bp_out", longint'($signed(out)), 4);
            end
        end

        for (int c = 0; c < 400; c++) begin
            valid_input = ($urandom_range(0, 9) < 7);
            last_input = ($urandom_range(0, 3) == 0);
            in0 = rand_lanes();
            in1 = rand_lanes();
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end
        valid_input = 1'b0;
        last_input = 1'b1;
        in0 = rep(1);
        in1 = rep(1);
        valid_input = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        valid_input = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sb_drain", longint'(exp_v.size()), 0);
        sb_en = 1'b0;

        // clear_acc mid-vector flushes the partial sum and drops the beat offered alongside it.
        send(rep(1), rep(1), 1'b0);
        send(rep(1), rep(1), 1'b0);
        clear_acc = 1'b1;
        in0 = rep(5);
        in1 = rep(5);
        last_input = 1'b1;
        @(posedge clk);
        #1;
        clear_acc = 1'b0;
        valid_input = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) n++;
            @(posedge clk);
            #1;
        end
        check("clr_noout", longint'(n), 0);
        send(rep(1), rep(1), 1'b1);
        valid_input = 1'b0;
        wait_out(got);
        check("clr_vld", longint'(got), 1);
        check("clr_out", longint'($signed(out)), 4);
        check("clr_cnt", longint'(out_count), 1);
        check("clr_sat", longint'(out_sat), 0);
        @(posedge clk);
        #1;

        // Async reset while a saturated result is held and a partial vector sits in the pipe.
        out_ready = 1'b0;
        send(rep(-32768), rep(-32768), 1'b0);
        send(rep(-32768), rep(-32768), 1'b1);
        send(rep(1), rep(1), 1'b0);
        valid_input = 1'b0;
        wait_out(got);
        check("ar_pre_out", longint'($signed(out)), MAXV);
        check("ar_pre_sat", longint'(out_sat), 1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_vld", longint'(out_valid), 0);
        check("ar_out", longint'(out), 0);
        check("ar_sat", longint'(out_sat), 0);
        check("ar_cnt", longint'(out_count), 0);
        check("ar_rdy", longint'(input_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(rep(1), rep(1), 1'b1);
        valid_input = 1'b0;
        wait_out(got);
        check("ar_post_vld", longint'(got), 1);
        check("ar_post_out", longint'($signed(out)), 4);
        check("ar_post_cnt", longint'(out_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
